// File: rtl/lsu_mem_stage_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage_if
// Data-memory bus between the load/store stage and the data memory.
// One request at a time: a request is transferred on
// mem_req_valid & mem_req_ready, and it is completed by a one-cycle
// mem_rsp_valid. For reads, mem_rsp_valid also carries mem_rdata.
//
// Signals:
//   mem_req_valid  master->slave  request valid
//   mem_req_ready  slave->master  memory accepts the request
//   mem_addr       master->slave  8-byte-aligned address (AW bits)
//   mem_wen        master->slave  1 = write
//   mem_wdata      master->slave  lane-shifted store data (64 bits)
//   mem_wmask      master->slave  byte-lane write strobe (0 on reads)
//   mem_rsp_valid  slave->master  read data valid / write acknowledge
//   mem_rdata      slave->master  read data (64 bits)
// ---------------------------------------------------------------------------
interface lsu_mem_stage_if #(
    parameter int AW = 64
);
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [63:0]   mem_wdata;
    logic [7:0]    mem_wmask;
    logic          mem_rsp_valid;
    logic [63:0]   mem_rdata;

    modport master (
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage
// This is the load/store stage that sits behind the ALU. It accepts one
// instruction at a time from EX. For a load or a store, it issues a single
// request on the data-memory bus and waits for the response. A load result
// is aligned and sign- or zero-extended. The final value is handed to WB
// with a valid/ready handshake. Non-memory instructions pass their ALU
// result straight through.
//
// Optional build macro: LSU_MISALIGN_CHECK_EN
//   defined   : a load/store whose byte offset is not a multiple of its size
//               skips the bus. It completes with out_err=1 and out_data=0.
//   undefined : out_err stays 0. The low offset bits are masked to the
//               natural alignment of the access size.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   EX handshake (in_ready high only while idle)
//   in_addr             effective address or pass-through value
//   in_wdata            store data (rs2)
//   in_memrd/in_memwr   load / store (store wins when both are set)
//   in_memop            lb,lh,lw,ld,lbu,lhu,lwu (3'b111 behaves as ld)
//   mem                 data-memory bus (lsu_mem_stage_if.master)
//   out_valid/out_ready WB handshake
//   out_data            load result, pass-through value, or 0 for stores
//   out_err             misaligned access flag
// ---------------------------------------------------------------------------
module lsu_mem_stage #(
    parameter  int AW = 64,
    localparam int DW = 64,
    localparam int NB = DW / 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AW-1:0]          in_addr,
    input  logic [DW-1:0]          in_wdata,
    input  logic                   in_memrd,
    input  logic                   in_memwr,
    input  logic [2:0]             in_memop,
    lsu_mem_stage_if.master        mem,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_data,
    output logic                   out_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Unshifted byte-lane strobe for an access of 2**sz bytes.
    function automatic logic [NB-1:0] size_mask(input logic [1:0] sz);
        logic [NB-1:0] m;
        case (sz)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Clears the offset bits below the natural alignment of the access size.
    function automatic logic [2:0] align_off(input logic [2:0] off, input logic [1:0] sz);
        logic [2:0] a;
        case (sz)
            2'd0:    a = off;
            2'd1:    a = {off[2:1], 1'b0};
            2'd2:    a = {off[2], 2'b00};
            default: a = 3'b000;
        endcase
        return a;
    endfunction

    // Sign- (op[2]=0) or zero- (op[2]=1) extension from the access size.
    function automatic logic [DW-1:0] load_extend(input logic [DW-1:0] raw, input logic [2:0] op);
        logic [DW-1:0] r;
        case (op[1:0])
            2'd0:    r = op[2] ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            2'd1:    r = op[2] ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'd2:    r = op[2] ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    state_t         state_r;
    state_t         state_nxt;
    logic           capture_s;
    logic           rsp_take_s;

    logic [2:0]     in_off_s;
    logic [1:0]     in_sz_s;
    logic           in_mem_s;
    logic [2:0]     lane_off_s;
    logic           misalign_s;
    logic [DW-1:0]  rdata_shift_s;
    logic [DW-1:0]  load_val_s;

    logic           in_ready_r;
    logic           mem_req_valid_r;
    logic [AW-1:0]  mem_addr_r;
    logic           mem_wen_r;
    logic [DW-1:0]  mem_wdata_r;
    logic [NB-1:0]  mem_wmask_r;
    logic           out_valid_r;
    logic [DW-1:0]  out_data_r;
    logic           out_err_r;
    logic [2:0]     memop_r;
    logic [2:0]     off_r;

    assign in_off_s   = in_addr[2:0];
    assign in_sz_s    = in_memop[1:0];
    assign in_mem_s   = in_memrd | in_memwr;
    assign lane_off_s = align_off(in_off_s, in_sz_s);

`ifdef LSU_MISALIGN_CHECK_EN
    // Any offset bit that alignment would have cleared marks the access misaligned.
    assign misalign_s = in_mem_s & (in_off_s != lane_off_s);
`else
    assign misalign_s = 1'b0;
`endif

    assign rdata_shift_s = mem.mem_rdata >> {off_r, 3'b000};
    assign load_val_s    = load_extend(rdata_shift_s, memop_r);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // FSM next-state and datapath strobes.
    always_comb begin
        state_nxt  = state_r;
        capture_s  = 1'b0;
        rsp_take_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    capture_s = 1'b1;
                    if (in_mem_s && !misalign_s) begin
                        state_nxt = ST_REQ;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                // mem_req_valid is registered high for exactly this state.
                if (mem.mem_req_ready) begin
                    state_nxt = ST_WAIT;
                end else begin
                    state_nxt = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem.mem_rsp_valid) begin
                    rsp_take_s = 1'b1;
                    state_nxt  = ST_DONE;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered handshake outputs and captured request/result datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r      <= 1'b1;
            mem_req_valid_r <= 1'b0;
            out_valid_r     <= 1'b0;
            mem_addr_r      <= '0;
            mem_wen_r       <= 1'b0;
            mem_wdata_r     <= 64'd0;
            mem_wmask_r     <= 8'd0;
            out_data_r      <= 64'd0;
            out_err_r       <= 1'b0;
            memop_r         <= 3'd0;
            off_r           <= 3'd0;
        end else begin
            // Handshake flags track the state being entered, so they are exact state decodes.
            in_ready_r      <= (state_nxt == ST_IDLE);
            mem_req_valid_r <= (state_nxt == ST_REQ);
            out_valid_r     <= (state_nxt == ST_DONE);
            if (capture_s) begin
                mem_addr_r  <= {in_addr[AW-1:3], 3'b000};
                mem_wen_r   <= in_memwr;
                mem_wmask_r <= in_memwr ? (size_mask(in_sz_s) << lane_off_s) : 8'd0;
                mem_wdata_r <= in_memwr ? (in_wdata << {lane_off_s, 3'b000}) : 64'd0;
                memop_r     <= in_memop;
                off_r       <= lane_off_s;
                // Memory accesses start at 0; only a load response replaces it.
                out_data_r  <= in_mem_s ? 64'd0 : 64'(in_addr);
                out_err_r   <= misalign_s;
            end else if (rsp_take_s) begin
                out_data_r  <= mem_wen_r ? 64'd0 : load_val_s;
            end else if ((state_r == ST_DONE) && out_ready) begin
                out_err_r   <= 1'b0;
            end else begin
                out_err_r   <= out_err_r;
            end
        end
    end

    assign in_ready          = in_ready_r;
    assign mem.mem_req_valid = mem_req_valid_r;
    assign mem.mem_addr      = mem_addr_r;
    assign mem.mem_wen       = mem_wen_r;
    assign mem.mem_wdata     = mem_wdata_r;
    assign mem.mem_wmask     = mem_wmask_r;
    assign out_valid         = out_valid_r;
    assign out_data          = out_data_r;
    assign out_err           = out_err_r;

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store stage directly downstream of the ALU; takes the ALU result as the effective address and the rs2 value as store data.
- Issues one request at a time on a simple 64-bit valid/ready data-memory bus, waits for the response, and aligns and extends load data.
- Presents the writeback value to the WB stage with a valid/ready handshake.
- Also passes non-memory instructions through so the pipeline has a single path.

Parameters:
- AW, 64, address width (ALU result width).
- DW, 64, data bus width; fixed at 64, byte lanes = DW/8.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  EX stage holds a valid instruction
- in_ready  out  1  stage can accept (high only in IDLE)
- in_addr  in  AW  ALU result: effective address, or writeback value for non-memory instructions
- in_wdata  in  64  R_rs2 store data
- in_memrd  in  1  load
- in_memwr  in  1  store
- in_memop  in  3  000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu; 111 treated as ld
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  AW  8-byte-aligned address {in_addr[AW-1:3],3'b0}
- mem_wen  out  1  1 = write
- mem_wdata  out  64  lane-shifted store data
- mem_wmask  out  8  byte-lane write strobe (0 on reads)
- mem_rsp_valid  in  1  read data valid / write acknowledge
- mem_rdata  in  64  read data
- out_valid  out  1  writeback value valid
- out_ready  in  1  WB stage accepts
- out_data  out  64  load result or passed-through in_addr (0 for stores)
- out_err  out  1  misaligned access flag (see Optional Feature)

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset: async; state=IDLE; mem_req_valid=0, mem_wen=0, mem_wmask=0, mem_addr=0, mem_wdata=0, out_valid=0, out_data=0, out_err=0, in_ready=1 after release.
- IDLE:
  - in_ready=1.
  - On in_valid, capture addr, wdata, memop, memrd, memwr.
  - If memrd|memwr, go to REQ; else go to DONE with out_data=in_addr.
  - memrd and memwr both high: store takes priority.
- REQ:
  - mem_req_valid=1; mem_addr, mem_wen, mem_wdata and mem_wmask are held stable until the handshake.
  - On mem_req_valid & mem_req_ready, go to WAIT.
- WAIT:
  - mem_req_valid=0.
  - On mem_rsp_valid, go to DONE.
  - A load registers out_data = extend(mem_rdata >> (8*off)); a store registers out_data=0.
  - mem_rsp_valid in any other state is ignored.
- DONE:
  - out_valid=1, with out_data/out_err stable.
  - On out_ready, go to IDLE; the next in_valid can be accepted the following cycle.
- Minimum latency: accept at t, req at t+1, rsp at t+2 or later, out_valid from the cycle after rsp. Pass-through: out_valid at t+1.
- Lane rules, with off=addr[2:0] and size = memop[1:0] (1,2,4,8 bytes):
  - mem_wmask = ((1<<size)-1) << off.
  - mem_wdata = in_wdata << (8*off).
- Alignment without the macro: off is forced to natural alignment (half clears off[0], word clears off[1:0], double uses off=0).
- Extension: memop[2]=0 sign-extends from bit 8*size-1; memop[2]=1 zero-extends.
- Reset mid-operation: pending request is dropped immediately; a late response after reset is ignored.
- Only one transaction is outstanding at a time; there is no request pipelining.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined:
  - A load/store whose off is not a multiple of its size skips REQ/WAIT and goes IDLE→DONE.
  - Result: out_err=1, out_data=0, no memory request issued.
  - out_err clears when DONE is left.
- Undefined: out_err tied 0; the low address bits are masked as described under Lane rules.

Test Plan:
- lbu addr=0x80000003, mem_rdata=0x1122334455667788 → mem_addr=0x80000000, out_data=0x0000000000000055.
- lh addr=0x80000006, rdata=0x8001_0000_0000_0000 → out_data=0xFFFFFFFFFFFF8001; lhu, same data → 0x0000000000008001.
- sw addr=0x80000004, rs2=0xDEADBEEFCAFEF00D → mem_wen=1, mem_wmask=0xF0, mem_wdata=0xCAFEF00D00000000, out_data=0.
- Pass-through (memrd=memwr=0), in_addr=0x1234 → no mem_req_valid, out_valid at t+1, out_data=0x1234.
- Backpressure: mem_req_ready low 3 cycles, rsp 2 cycles later, out_ready low 2 cycles → request fields stable, in_ready=0 throughout, out_data stable until the handshake.
- rst_n pulled low in WAIT → mem_req_valid/out_valid 0 immediately; a later rsp is ignored. With LSU_MISALIGN_CHECK_EN, lw at 0x80000002 → out_err=1, no request.
